// File: rtl/mem_responder.sv
// mem_responder: registered, handshaked single-port word store for the CPU
// memory bus. A request is captured in IDLE, optionally waits WAIT_CYCLES
// cycles, then commits (write or read) on the edge entering RESP, where ack
// pulses for one cycle.
//
// Optional build macro MEM_RESPONDER_IO_EN: maps the top word address
// (all ones) onto an output register io_out with a write strobe io_stb
// instead of the storage array.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
`ifdef MEM_RESPONDER_IO_EN
    output logic [DATA_W-1:0] io_out,
    output logic              io_stb,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] IO_ADDR = '1;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                commit;
    logic                mem_wr;

`ifdef MEM_RESPONDER_IO_EN
    logic [DATA_W-1:0]   io_out_q, io_out_d;
`endif

    // Storage is never cleared, so its contents survive reset.
    logic [DATA_W-1:0]   mem [DEPTH];

    // State register; reset has priority over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, RESP always returns.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture and wait counter; inputs are only looked at in IDLE.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE && req) begin
            addr_d  = addr;
            wdata_d = wdata;
            we_d    = we;
            cnt_d   = WAIT_LOAD;
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Commit happens on the edge entering RESP; with zero wait states that is
    // the capture edge itself, so the *_d values are the ones to commit.
    always_comb begin
        commit  = (state_d == ST_RESP) && (state_q != ST_RESP) && !rst;
        mem_wr  = 1'b0;
        rdata_d = rdata_q;
`ifdef MEM_RESPONDER_IO_EN
        io_out_d = io_out_q;
        if (commit) begin
            if (we_d) begin
                if (addr_d == IO_ADDR) begin
                    io_out_d = wdata_d;
                end else begin
                    mem_wr = 1'b1;
                end
            end else begin
                rdata_d = (addr_d == IO_ADDR) ? io_out_q : mem[addr_d];
            end
        end
`else
        if (commit) begin
            if (we_d) begin
                mem_wr = 1'b1;
            end else begin
                rdata_d = mem[addr_d];
            end
        end
`endif
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_RESPONDER_IO_EN
    // Memory-mapped output register at the top address.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_out_q <= '0;
        end else begin
            io_out_q <= io_out_d;
        end
    end
`endif

    // Storage write port; mem_wr is already suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[addr_d] <= wdata_d;
        end
    end

    // Outputs are decoded from the registered state only.
    always_comb begin
        ack   = (state_q == ST_RESP);
        busy  = (state_q != ST_IDLE);
        rdata = rdata_q;
`ifdef MEM_RESPONDER_IO_EN
        io_out = io_out_q;
        io_stb = (state_q == ST_RESP) && we_q && (addr_q == IO_ADDR);
`endif
    end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances with 2, 0 and 3 wait states
// share one clock and reset. A simple array model of the store and of the
// held read data predicts every response and its timing.
module tb_mem_responder;

    localparam int N_DUT = 3;

    // Wait states per instance.
    function automatic int wait_of(input int g);
        if (g == 0) return 2;
        else if (g == 1) return 0;
        else return 3;
    endfunction

    logic        clk;
    logic        rst;
    logic        req_s   [N_DUT];
    logic        we_s    [N_DUT];
    logic [7:0]  addr_s  [N_DUT];
    logic [15:0] wdata_s [N_DUT];
    logic [15:0] rdata_s [N_DUT];
    logic        ack_s   [N_DUT];
    logic        busy_s  [N_DUT];
`ifdef MEM_RESPONDER_IO_EN
    logic [15:0] io_out_s [N_DUT];
    logic        io_stb_s [N_DUT];
`endif

    // Reference model: what each instance's store, held read data and
    // output register should contain.
    logic [15:0] model_mem [N_DUT][256];
    logic [15:0] model_rd  [N_DUT];
    logic [15:0] model_io  [N_DUT];

    int n_vec;
    int n_err;

    for (genvar g = 0; g < N_DUT; g++) begin : gen_dut
        mem_responder #(
            .ADDR_W     (8),
            .DATA_W     (16),
            .WAIT_CYCLES(wait_of(g))
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .req   (req_s[g]),
            .we    (we_s[g]),
            .addr  (addr_s[g]),
            .wdata (wdata_s[g]),
            .rdata (rdata_s[g]),
            .ack   (ack_s[g]),
`ifdef MEM_RESPONDER_IO_EN
            .io_out(io_out_s[g]),
            .io_stb(io_stb_s[g]),
`endif
            .busy  (busy_s[g])
        );
    end

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Update the model for a completed access, per the bus rules.
    task automatic model_access(input int i, input bit w, input logic [7:0] a, input logic [15:0] d);
`ifdef MEM_RESPONDER_IO_EN
        if (a == 8'hFF) begin
            if (w) model_io[i] = d;
            else   model_rd[i] = model_io[i];
            return;
        end
`endif
        if (w) model_mem[i][a] = d;
        else   model_rd[i] = model_mem[i][a];
    endtask

    // Expected rdata at the ack of an access, computed before the model update.
    function automatic logic [15:0] expect_rd(input int i, input bit w, input logic [7:0] a);
        if (w) return model_rd[i];
`ifdef MEM_RESPONDER_IO_EN
        if (a == 8'hFF) return model_io[i];
`endif
        return model_mem[i][a];
    endfunction

    // Issue one request just after an edge and observe the response.
    // Inputs are scrambled after acceptance to show they are ignored.
    task automatic drive_access(input int i, input bit w, input logic [7:0] a, input logic [15:0] d,
                                output int ack_k, output logic [15:0] rd_at_ack,
                                output logic busy_k1, output logic ack_after, output logic busy_after);
        @(posedge clk); #1;
        req_s[i] = 1'b1; we_s[i] = w; addr_s[i] = a; wdata_s[i] = d;
        ack_k = -1; rd_at_ack = '0; busy_k1 = 1'b0; ack_after = 1'b1; busy_after = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack_k > 0 && k == ack_k + 1) begin
                ack_after  = ack_s[i];
                busy_after = busy_s[i];
                break;
            end
            if (k == 1) begin
                busy_k1    = busy_s[i];
                req_s[i]   = 1'b0;
                we_s[i]    = 1'($urandom);
                addr_s[i]  = 8'($urandom);
                wdata_s[i] = 16'($urandom);
            end
            if (ack_s[i] && ack_k < 0) begin
                ack_k     = k;
                rd_at_ack = rdata_s[i];
            end
        end
    endtask

    // Reset all instances for two cycles and check the idle outputs.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            model_rd[i] = '0;
            model_io[i] = '0;
            n_vec++;
            if (ack_s[i] !== 1'b0) begin
                n_err++; $display("[TB] FAIL reset_ack dut%0d got %b want 0", i, ack_s[i]);
            end
            n_vec++;
            if (busy_s[i] !== 1'b0) begin
                n_err++; $display("[TB] FAIL reset_busy dut%0d got %b want 0", i, busy_s[i]);
            end
            n_vec++;
            if (rdata_s[i] !== 16'h0000) begin
                n_err++; $display("[TB] FAIL reset_rdata dut%0d got %h want 0000", i, rdata_s[i]);
            end
`ifdef MEM_RESPONDER_IO_EN
            n_vec++;
            if (io_out_s[i] !== 16'h0000) begin
                n_err++; $display("[TB] FAIL reset_io_out dut%0d got %h want 0000", i, io_out_s[i]);
            end
`endif
        end
    endtask

    // Fill every word of every instance over the bus, checking write latency.
    task automatic test_preload();
        int          ack_k;
        logic [15:0] rd, d;
        logic        b1, aa, ba;
        for (int i = 0; i < N_DUT; i++) begin
            for (int a = 0; a < 256; a++) begin
                d = 16'($urandom);
                if (a == 8'h0D) d = 16'h0005;
                if (a == 8'h40) d = 16'hA5A5;
                if (a == 8'h30) d = 16'h7E57;
                drive_access(i, 1'b1, 8'(a), d, ack_k, rd, b1, aa, ba);
                model_access(i, 1'b1, 8'(a), d);
                n_vec++;
                if (ack_k != 1 + wait_of(i)) begin
                    n_err++; $display("[TB] FAIL preload_latency dut%0d addr %h got %0d want %0d", i, a, ack_k, 1 + wait_of(i));
                end
            end
        end
    endtask

    // Read of a preloaded word with two wait states.
    task automatic test_read();
        int          ack_k;
        logic [15:0] rd;
        logic        b1, aa, ba;
        drive_access(0, 1'b0, 8'h0D, 16'h0000, ack_k, rd, b1, aa, ba);
        model_access(0, 1'b0, 8'h0D, 16'h0000);
        n_vec++;
        if (b1 !== 1'b1) begin
            n_err++; $display("[TB] FAIL read_busy got %b want 1", b1);
        end
        n_vec++;
        if (ack_k != 3) begin
            n_err++; $display("[TB] FAIL read_latency got %0d want 3", ack_k);
        end
        n_vec++;
        if (rd !== 16'h0005) begin
            n_err++; $display("[TB] FAIL read_data got %h want 0005", rd);
        end
        n_vec++;
        if (aa !== 1'b0 || ba !== 1'b0) begin
            n_err++; $display("[TB] FAIL read_ack_pulse got ack=%b busy=%b want 0 0", aa, ba);
        end
    endtask

    // Zero wait states: write then read back the same word.
    task automatic test_write_read();
        int          ack_k;
        logic [15:0] rd, prev;
        logic        b1, aa, ba;
        prev = model_rd[1];
        drive_access(1, 1'b1, 8'h20, 16'hBEEF, ack_k, rd, b1, aa, ba);
        model_access(1, 1'b1, 8'h20, 16'hBEEF);
        n_vec++;
        if (ack_k != 1) begin
            n_err++; $display("[TB] FAIL wr0_latency got %0d want 1", ack_k);
        end
        n_vec++;
        if (rd !== prev) begin
            n_err++; $display("[TB] FAIL wr0_rdata_held got %h want %h", rd, prev);
        end
        drive_access(1, 1'b0, 8'h20, 16'h0000, ack_k, rd, b1, aa, ba);
        model_access(1, 1'b0, 8'h20, 16'h0000);
        n_vec++;
        if (rd !== 16'hBEEF || ack_k != 1) begin
            n_err++; $display("[TB] FAIL raw0_data got %h at %0d want BEEF at 1", rd, ack_k);
        end
    endtask

    // A second request raised during WAIT must be dropped, not queued.
    task automatic test_ignored_req();
        int          acks, ack_k;
        logic [15:0] rd;
        logic        b1, aa, ba;
        acks = 0; rd = '0;
        @(posedge clk); #1;
        req_s[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 8'h0D; wdata_s[0] = 16'h0000;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack_s[0]) begin
                acks++;
                rd = rdata_s[0];
            end
            if (k == 1) begin
                we_s[0] = 1'b1; addr_s[0] = 8'h30; wdata_s[0] = 16'h1111;
            end
            if (k == 3) req_s[0] = 1'b0;
        end
        model_access(0, 1'b0, 8'h0D, 16'h0000);
        n_vec++;
        if (acks != 1) begin
            n_err++; $display("[TB] FAIL ignored_ack_count got %0d want 1", acks);
        end
        n_vec++;
        if (rd !== 16'h0005) begin
            n_err++; $display("[TB] FAIL ignored_rdata got %h want 0005", rd);
        end
        drive_access(0, 1'b0, 8'h30, 16'h0000, ack_k, rd, b1, aa, ba);
        n_vec++;
        if (rd !== model_mem[0][8'h30]) begin
            n_err++; $display("[TB] FAIL ignored_mem30 got %h want %h", rd, model_mem[0][8'h30]);
        end
        model_access(0, 1'b0, 8'h30, 16'h0000);
    endtask

    // Reset asserted on the would-be commit edge of a write drops the write.
    task automatic test_reset_mid_write();
        int          acks, ack_k;
        logic [15:0] rd;
        logic        b1, aa, ba;
        acks = 0;
        @(posedge clk); #1;
        req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 8'h40; wdata_s[2] = 16'h1234;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (ack_s[2]) acks++;
            if (k == 1) req_s[2] = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) begin
                n_vec++;
                if (busy_s[2] !== 1'b0 || rdata_s[2] !== 16'h0000) begin
                    n_err++; $display("[TB] FAIL rstmid_idle got busy=%b rdata=%h want 0 0000", busy_s[2], rdata_s[2]);
                end
                rst = 1'b0;
                for (int i = 0; i < N_DUT; i++) begin
                    model_rd[i] = '0;
                    model_io[i] = '0;
                end
            end
        end
        n_vec++;
        if (acks != 0) begin
            n_err++; $display("[TB] FAIL rstmid_ack_count got %0d want 0", acks);
        end
        drive_access(2, 1'b0, 8'h40, 16'h0000, ack_k, rd, b1, aa, ba);
        n_vec++;
        if (rd !== 16'hA5A5) begin
            n_err++; $display("[TB] FAIL rstmid_mem40 got %h want A5A5", rd);
        end
        model_access(2, 1'b0, 8'h40, 16'h0000);
    endtask

    // req held high: each IDLE sample is a new request, spaced WAIT+2 cycles.
    task automatic test_back_to_back(input int i);
        int          j, ack_k, w;
        int          ack_pos [3];
        logic [15:0] dat [3];
        logic [15:0] rd;
        logic        b1, aa, ba;
        w = wait_of(i);
        j = 0;
        for (int n = 0; n < 3; n++) begin
            dat[n] = 16'($urandom);
            ack_pos[n] = -1;
        end
        @(posedge clk); #1;
        req_s[i] = 1'b1; we_s[i] = 1'b1; addr_s[i] = 8'h50; wdata_s[i] = dat[0];
        for (int k = 1; k <= 3 * (w + 2) + 4; k++) begin
            @(posedge clk); #1;
            if (ack_s[i]) begin
                if (j < 3) ack_pos[j] = k;
                j++;
                if (j < 3) begin
                    addr_s[i] = 8'(8'h50 + j); wdata_s[i] = dat[j];
                end else begin
                    req_s[i] = 1'b0;
                end
            end
        end
        req_s[i] = 1'b0;
        n_vec++;
        if (j != 3) begin
            n_err++; $display("[TB] FAIL b2b_ack_count dut%0d got %0d want 3", i, j);
        end
        for (int n = 0; n < 3; n++) begin
            model_access(i, 1'b1, 8'(8'h50 + n), dat[n]);
            n_vec++;
            if (ack_pos[n] != 1 + w + n * (w + 2)) begin
                n_err++; $display("[TB] FAIL b2b_ack_pos dut%0d #%0d got %0d want %0d", i, n, ack_pos[n], 1 + w + n * (w + 2));
            end
        end
        for (int n = 0; n < 3; n++) begin
            drive_access(i, 1'b0, 8'(8'h50 + n), 16'h0000, ack_k, rd, b1, aa, ba);
            model_access(i, 1'b0, 8'(8'h50 + n), 16'h0000);
            n_vec++;
            if (rd !== dat[n]) begin
                n_err++; $display("[TB] FAIL b2b_readback dut%0d #%0d got %h want %h", i, n, rd, dat[n]);
            end
        end
    endtask

    // Random mix of reads and writes, half to a small hot range for RAW hazards.
    task automatic test_random();
        int          ack_k;
        logic [15:0] rd, d, exp_rd;
        logic [7:0]  a;
        logic        b1, aa, ba;
        bit          w;
        for (int i = 0; i < N_DUT; i++) begin
            for (int n = 0; n < 40; n++) begin
                w = 1'($urandom);
                a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                d = 16'($urandom);
                exp_rd = expect_rd(i, w, a);
                drive_access(i, w, a, d, ack_k, rd, b1, aa, ba);
                model_access(i, w, a, d);
                n_vec++;
                if (ack_k != 1 + wait_of(i) || aa !== 1'b0 || b1 !== 1'b1) begin
                    n_err++; $display("[TB] FAIL rand_timing dut%0d got ack@%0d busy1=%b ackafter=%b want ack@%0d 1 0", i, ack_k, b1, aa, 1 + wait_of(i));
                end
                n_vec++;
                if (rd !== exp_rd) begin
                    n_err++; $display("[TB] FAIL rand_rdata dut%0d we=%b addr=%h got %h want %h", i, w, a, rd, exp_rd);
                end
            end
        end
    endtask

`ifdef MEM_RESPONDER_IO_EN
    // Write and read back the memory-mapped output register.
    task automatic test_io();
        int          stb_cnt, stb_k, ack_k;
        logic [15:0] rd;
        logic        b1, aa, ba;
        stb_cnt = 0; stb_k = -1;
        @(posedge clk); #1;
        req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 8'hFF; wdata_s[0] = 16'h00A5;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) req_s[0] = 1'b0;
            if (io_stb_s[0]) begin
                stb_cnt++;
                if (ack_s[0]) stb_k = k;
            end
        end
        model_access(0, 1'b1, 8'hFF, 16'h00A5);
        n_vec++;
        if (stb_cnt != 1 || stb_k != 3) begin
            n_err++; $display("[TB] FAIL io_stb got count=%0d at %0d want 1 at 3", stb_cnt, stb_k);
        end
        n_vec++;
        if (io_out_s[0] !== 16'h00A5) begin
            n_err++; $display("[TB] FAIL io_out got %h want 00A5", io_out_s[0]);
        end
        drive_access(0, 1'b0, 8'hFF, 16'h0000, ack_k, rd, b1, aa, ba);
        model_access(0, 1'b0, 8'hFF, 16'h0000);
        n_vec++;
        if (rd !== 16'h00A5) begin
            n_err++; $display("[TB] FAIL io_read got %h want 00A5", rd);
        end
    endtask
`endif

    // Run every scenario in order, then print the summary.
    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
            model_rd[i] = '0; model_io[i] = '0;
        end
        test_reset();
        test_preload();
        test_read();
        test_write_read();
        test_ignored_req();
        test_reset_mid_write();
        test_back_to_back(0);
        test_back_to_back(1);
        test_random();
`ifdef MEM_RESPONDER_IO_EN
        test_io();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
